adma_dm_axi_w_strb: RTL and testbench
=====================================

Name: adma_dm_axi_w_strb

Overview:
- Next-generation AXI write-data mover for the ADMA data-mover path.
- Accepts per-burst descriptors (length plus first/last byte offsets) and a stream of destination data beats.
- Drives the AXI W channel with WDATA, generated WSTRB for unaligned start/end bytes, and WLAST.
- Sits between the destination data buffer and the AXI master port.
- Supports a parametrised number of outstanding bursts and any power-of-two data width.

Parameters:
- ATX_LEN_W, 8, width of the AWLEN field (beats minus one).
- ATX_DST_DATA_W, 256, W data width in bits; power of two, 16 to 1024.
- ATX_NUM_OSTD, 4, depth of the descriptor queue (outstanding bursts); power of two, at least 2.
- Derived STRB_W = ATX_DST_DATA_W/8.
- Derived OFF_W = log2(STRB_W).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- atx_awlen  in  ATX_LEN_W  burst length minus one.
- atx_first_off  in  OFF_W  byte offset of the first valid byte in beat 0.
- atx_last_off  in  OFF_W  byte index of the last valid byte in the final beat.
- atx_vld  in  1  descriptor valid.
- atx_rdy  out  1  descriptor queue not full.
- atx_wdata  in  ATX_DST_DATA_W  data beat from the buffer.
- atx_wdata_vld  in  1  data beat valid.
- atx_wdata_rdy  out  1  data beat accepted.
- m_wdata_o  out  ATX_DST_DATA_W  AXI WDATA.
- m_wstrb_o  out  STRB_W  AXI WSTRB.
- m_wlast_o  out  1  AXI WLAST.
- m_wvalid_o  out  1  AXI WVALID.
- m_wready_i  in  1  AXI WREADY.
- ostd_cnt_o  out  log2(ATX_NUM_OSTD)+1  number of descriptors queued or in progress.
- busy_o  out  1  high when ostd_cnt_o is non-zero or m_wvalid_o is high.

Behaviour:
- Reset values:
  - m_wvalid_o=0, m_wlast_o=0, m_wstrb_o=0, m_wdata_o=0, ostd_cnt_o=0, busy_o=0.
  - atx_rdy=1; atx_wdata_rdy=0.
  - Beat counter=0; descriptor queue empty.
- Descriptor queue:
  - Synchronous FIFO of {awlen, first_off, last_off}, depth ATX_NUM_OSTD.
  - A push occurs when atx_vld & atx_rdy.
  - atx_rdy = not full, evaluated at the start of the cycle; no same-cycle pass-through when full, even if a pop occurs.
  - A descriptor pushed into an empty queue becomes visible the next cycle.
  - Pop occurs on the handshake of the last data beat.
- Beat counter (ATX_LEN_W bits):
  - Increments on each data handshake.
  - Clears to 0 when the handshaked beat has count == awlen.
  - Never wraps past awlen. awlen=255 gives 256 beats.
- atx_wdata_rdy = head descriptor valid & output slice can accept.
- Strobe generation (combinational from head descriptor and counter):
  - first_mask = all-ones << first_off.
  - last_mask = all-ones >> (STRB_W-1-last_off).
  - Beat 0 uses first_mask.
  - Beat awlen uses last_mask.
  - A single-beat burst (awlen=0) uses first_mask & last_mask.
  - Middle beats are all-ones.
  - If first_off > last_off on a single-beat burst, wstrb is 0; the beat is still sent with wlast=1.
- Output slice:
  - Full 2-entry skid register on {wdata, wstrb, wlast}.
  - Latency is 1 cycle from data handshake to m_wvalid_o.
  - Sustains 1 beat/cycle under continuous m_wready_i.
  - Outputs are held stable while m_wvalid_o & ~m_wready_i (AXI rule); m_wvalid_o never drops without a handshake.
- Back-to-back bursts: the first beat of the next burst may be accepted in the cycle after the last beat of the previous one. No bubble is required.
- ostd_cnt_o:
  - +1 on push; -1 when the last beat handshakes on the W channel (m_wvalid_o & m_wready_i & m_wlast_o).
  - Simultaneous +1/-1 leaves it unchanged.
- Reset mid-burst: all state is discarded asynchronously; the partially sent burst is abandoned.

Optional Feature:
- Macro ADMA_DM_W_ZERO_PAD_EN.
- Defined: data bytes whose wstrb bit is 0 are forced to 8'h00 in m_wdata_o.
- Undefined: m_wdata_o passes atx_wdata unmodified. Strobe behaviour is identical in both cases.

Decomposition:
- Package adma_dm_pkg:
  - STRB_W/OFF_W derivation function (clog2).
  - Descriptor struct typedef {len, first_off, last_off}.
  - Reset constants.
- Sub-module adma_dm_strb_gen: combinational mask generator (first_off, last_off, is_first, is_last -> strb).
- Descriptor queue reuses the existing sync_fifo; the output slice reuses the existing skid_buffer in full-register mode.

Test Plan:
- ATX_DST_DATA_W=32; descriptor awlen=3, first_off=2, last_off=1; 4 beats, wready=1.
  - Expected wstrb: 4'b1100, 4'b1111, 4'b1111, 4'b0011.
  - wlast only on beat 4; m_wvalid_o 1 cycle after each data handshake.
- Single beat awlen=0, first_off=1, last_off=2 -> wstrb=4'b0110, wlast=1.
  - With ADMA_DM_W_ZERO_PAD_EN, data 32'hAABBCCDD -> 32'h00BBCC00.
- Push 4 descriptors with no data.
  - atx_rdy low after the 4th push; ostd_cnt_o=4.
  - 5th push blocked until the last beat of burst 1 handshakes.
- Back-to-back bursts awlen=1 and awlen=0 with continuous data and wready.
  - 3 consecutive W beats with no bubble; wlast on beats 2 and 3.
- Random m_wready_i stalls (50%).
  - WDATA/WSTRB/WLAST stable during stalls; no beat lost or duplicated; ostd_cnt_o returns to 0.
- Assert rst_n mid-burst (after beat 2 of 4).
  - All outputs take reset values immediately; a new descriptor then runs correctly from beat 0.

Source files
------------

// File: rtl/adma_dm_pkg.sv
// rtl/adma_dm_pkg.sv - shared types, constants and width helpers for the ADMA data mover
package adma_dm_pkg;

    // Descriptor fields are stored at their widest legal size; the top zero-extends into them.
    localparam int DM_LEN_W_MAX = 16;
    localparam int DM_OFF_W_MAX = 7;

    typedef struct packed {
        logic [DM_LEN_W_MAX-1:0] len;
        logic [DM_OFF_W_MAX-1:0] first_off;
        logic [DM_OFF_W_MAX-1:0] last_off;
    } adma_dm_desc_t;

    localparam logic [DM_LEN_W_MAX-1:0] DM_BEAT_CNT_RST = '0;
    localparam logic [7:0]              DM_OSTD_CNT_RST = '0;

    function automatic int adma_dm_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/adma_dm_strb_gen.sv
// rtl/adma_dm_strb_gen.sv - byte strobe mask for the first, middle and last beats of a burst
module adma_dm_strb_gen #(
    parameter int STRB_W = 32,
    parameter int OFF_W  = 5
) (
    input  logic [OFF_W-1:0]  first_off,
    input  logic [OFF_W-1:0]  last_off,
    input  logic              is_first,
    input  logic              is_last,
    output logic [STRB_W-1:0] strb
);
    localparam logic [STRB_W-1:0] ONES = '1;

    logic [STRB_W-1:0] first_mask;
    logic [STRB_W-1:0] last_mask;

    assign first_mask = ONES << first_off;
    assign last_mask  = ONES >> (STRB_W - 1 - int'(last_off));
    // A single-beat burst with first_off > last_off yields an empty strobe.
    assign strb       = (is_first ? first_mask : ONES) & (is_last ? last_mask : ONES);

endmodule

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry fully registered skid buffer; in_tready depends only on local state
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready
);
    logic             skid_vld;
    logic [WIDTH-1:0] skid_data;

    assign in_tready = ~skid_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            skid_vld   <= 1'b0;
            skid_data  <= '0;
        end else if (out_tready || !out_tvalid) begin
            if (skid_vld) begin
                out_tdata  <= skid_data;
                out_tvalid <= 1'b1;
                skid_vld   <= 1'b0;
            end else begin
                out_tvalid <= in_tvalid;
                if (in_tvalid) out_tdata <= in_tdata;
            end
        end else if (in_tvalid && !skid_vld) begin
            // Output is stalled: park the accepted beat so the output stays stable.
            skid_vld  <= 1'b1;
            skid_data <= in_tdata;
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered pointers and first-word-visible read port
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en && !full)  wptr <= wptr + 1'b1;
            if (rd_en && !empty) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/adma_dm_axi_w_strb.sv
// rtl/adma_dm_axi_w_strb.sv - AXI W mover with WSTRB/WLAST generation; ADMA_DM_W_ZERO_PAD_EN zeroes unstrobed bytes
module adma_dm_axi_w_strb
    import adma_dm_pkg::*;
#(
    parameter int  ATX_LEN_W      = 8,
    parameter int  ATX_DST_DATA_W = 256,
    parameter int  ATX_NUM_OSTD   = 4,
    localparam int STRB_W         = ATX_DST_DATA_W / 8,
    localparam int OFF_W          = adma_dm_clog2(STRB_W),
    localparam int CNT_W          = adma_dm_clog2(ATX_NUM_OSTD) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ATX_LEN_W-1:0]      atx_awlen,
    input  logic [OFF_W-1:0]          atx_first_off,
    input  logic [OFF_W-1:0]          atx_last_off,
    input  logic                      atx_vld,
    output logic                      atx_rdy,
    input  logic [ATX_DST_DATA_W-1:0] atx_wdata,
    input  logic                      atx_wdata_vld,
    output logic                      atx_wdata_rdy,
    output logic [ATX_DST_DATA_W-1:0] m_wdata_o,
    output logic [STRB_W-1:0]         m_wstrb_o,
    output logic                      m_wlast_o,
    output logic                      m_wvalid_o,
    input  logic                      m_wready_i,
    output logic [CNT_W-1:0]          ostd_cnt_o,
    output logic                      busy_o
);
    localparam int SLICE_W = ATX_DST_DATA_W + STRB_W + 1;

    adma_dm_desc_t             desc_in;
    adma_dm_desc_t             head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      head_vld;
    logic                      push;
    logic                      pop;
    logic                      beat_hs;
    logic                      w_done;
    logic                      cnt_sat;
    logic                      is_first;
    logic                      is_last;
    logic [ATX_LEN_W-1:0]      beat_cnt;
    logic [DM_LEN_W_MAX-1:0]   beat_cnt_ext;
    logic [STRB_W-1:0]         strb;
    logic [ATX_DST_DATA_W-1:0] data_fmt;
    logic                      slice_in_rdy;
    logic [SLICE_W-1:0]        slice_out;

    always_comb begin
        desc_in                       = '0;
        desc_in.len[ATX_LEN_W-1:0]    = atx_awlen;
        desc_in.first_off[OFF_W-1:0]  = atx_first_off;
        desc_in.last_off[OFF_W-1:0]   = atx_last_off;
    end

    always_comb begin
        beat_cnt_ext                  = '0;
        beat_cnt_ext[ATX_LEN_W-1:0]   = beat_cnt;
    end

    // Beats of popped bursts can still sit in the slice, so the count may exceed the
    // queue depth; holding off pushes at saturation keeps the counter from wrapping.
    assign cnt_sat       = &ostd_cnt_o;
    assign atx_rdy       = ~fifo_full & ~cnt_sat;
    assign push          = atx_vld & atx_rdy;
    assign head_vld      = ~fifo_empty;
    assign atx_wdata_rdy = head_vld & slice_in_rdy;
    assign beat_hs       = atx_wdata_vld & atx_wdata_rdy;
    assign is_first      = (beat_cnt == '0);
    assign is_last       = (beat_cnt_ext == head.len);
    assign pop           = beat_hs & is_last;
    assign w_done        = m_wvalid_o & m_wready_i & m_wlast_o;
    assign busy_o        = (ostd_cnt_o != '0) | m_wvalid_o;

    sync_fifo #(
        .WIDTH ($bits(adma_dm_desc_t)),
        .DEPTH (ATX_NUM_OSTD)
    ) u_desc_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (desc_in),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty)
    );

    adma_dm_strb_gen #(
        .STRB_W (STRB_W),
        .OFF_W  (DM_OFF_W_MAX)
    ) u_strb_gen (
        .first_off (head.first_off),
        .last_off  (head.last_off),
        .is_first  (is_first),
        .is_last   (is_last),
        .strb      (strb)
    );

    always_comb begin
        data_fmt = atx_wdata;
`ifdef ADMA_DM_W_ZERO_PAD_EN
        for (int i = 0; i < STRB_W; i++) begin
            if (!strb[i]) data_fmt[8*i +: 8] = 8'h00;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= DM_BEAT_CNT_RST[ATX_LEN_W-1:0];
        end else if (beat_hs) begin
            beat_cnt <= is_last ? '0 : beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ostd_cnt_o <= DM_OSTD_CNT_RST[CNT_W-1:0];
        end else if (push && !w_done) begin
            ostd_cnt_o <= ostd_cnt_o + 1'b1;
        end else if (!push && w_done) begin
            ostd_cnt_o <= ostd_cnt_o - 1'b1;
        end
    end

    skid_buffer #(
        .WIDTH (SLICE_W)
    ) u_w_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_tdata   ({data_fmt, strb, is_last}),
        .in_tvalid  (atx_wdata_vld & head_vld),
        .in_tready  (slice_in_rdy),
        .out_tdata  (slice_out),
        .out_tvalid (m_wvalid_o),
        .out_tready (m_wready_i)
    );

    assign {m_wdata_o, m_wstrb_o, m_wlast_o} = slice_out;

endmodule

// File: tb/tb_adma_dm_axi_w_strb.sv
// tb/tb_adma_dm_axi_w_strb.sv - self-checking bench for adma_dm_axi_w_strb (32-bit data, 4 outstanding)
module tb_adma_dm_axi_w_strb;

    typedef struct {
        int len;
        int fo;
        int lo;
    } desc_m_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  atx_awlen = '0;
    logic [1:0]  atx_first_off = '0;
    logic [1:0]  atx_last_off = '0;
    logic        atx_vld = 1'b0;
    logic        atx_rdy;
    logic [31:0] atx_wdata = '0;
    logic        atx_wdata_vld = 1'b0;
    logic        atx_wdata_rdy;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_wlast_o;
    logic        m_wvalid_o;
    logic        m_wready_i = 1'b1;
    logic [2:0]  ostd_cnt_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    desc_m_t desc_q[$];
    beat_t   exp_q[$];
    int      w_cyc_q[$];
    logic    w_last_q[$];

    adma_dm_axi_w_strb #(
        .ATX_LEN_W      (8),
        .ATX_DST_DATA_W (32),
        .ATX_NUM_OSTD   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .atx_awlen     (atx_awlen),
        .atx_first_off (atx_first_off),
        .atx_last_off  (atx_last_off),
        .atx_vld       (atx_vld),
        .atx_rdy       (atx_rdy),
        .atx_wdata     (atx_wdata),
        .atx_wdata_vld (atx_wdata_vld),
        .atx_wdata_rdy (atx_wdata_rdy),
        .m_wdata_o     (m_wdata_o),
        .m_wstrb_o     (m_wstrb_o),
        .m_wlast_o     (m_wlast_o),
        .m_wvalid_o    (m_wvalid_o),
        .m_wready_i    (m_wready_i),
        .ostd_cnt_o    (ostd_cnt_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte i is written when it lies at/after first_off on beat 0 and at/before last_off on the final beat.
    function automatic logic [3:0] model_strb(input desc_m_t d, input int beat);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) begin
            s[i] = ((beat != 0) || (i >= d.fo)) && ((beat != d.len) || (i <= d.lo));
        end
        return s;
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] data, input logic [3:0] s);
        logic [31:0] r;
        r = data;
`ifdef ADMA_DM_W_ZERO_PAD_EN
        for (int i = 0; i < 4; i++) if (!s[i]) r[8*i +: 8] = 8'h00;
`endif
        return r;
    endfunction

    initial begin
        m_wready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_wready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // W-channel monitor: scoreboard compare on each handshake, hold check on each stall.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_d;
    logic [3:0]  prev_s;
    logic        prev_l;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", m_wvalid_o, 1'b1);
                check("hold_data", m_wdata_o, prev_d);
                check("hold_strb", m_wstrb_o, prev_s);
                check("hold_last", m_wlast_o, prev_l);
            end
            if (m_wvalid_o && m_wready_i) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("w_data", m_wdata_o, e.d);
                    check("w_strb", m_wstrb_o, e.s);
                    check("w_last", m_wlast_o, e.l);
                end
                w_cyc_q.push_back(cyc);
                w_last_q.push_back(m_wlast_o);
            end
            stall_prev = m_wvalid_o && !m_wready_i;
            prev_d = m_wdata_o;
            prev_s = m_wstrb_o;
            prev_l = m_wlast_o;
        end
    end

    task automatic push_desc(input int len, input int fo, input int lo);
        int n;
        desc_m_t d;
        atx_awlen = 8'(len);
        atx_first_off = 2'(fo);
        atx_last_off = 2'(lo);
        atx_vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (!atx_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!atx_rdy) check("desc_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        atx_vld = 1'b0;
        d.len = len;
        d.fo = fo;
        d.lo = lo;
        desc_q.push_back(d);
    endtask

    task automatic send_beat(input logic [31:0] data, input desc_m_t d, input int beat);
        int n;
        beat_t e;
        atx_wdata = data;
        atx_wdata_vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (!atx_wdata_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!atx_wdata_rdy) begin
            check("beat_timeout", 64'd0, 64'd1);
        end else begin
            e.s = model_strb(d, beat);
            e.d = model_data(data, e.s);
            e.l = (beat == d.len);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        atx_wdata_vld = 1'b0;
    endtask

    task automatic send_burst();
        int n;
        desc_m_t d;
        n = 0;
        while (desc_q.size() == 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (desc_q.size() == 0) begin
            check("burst_timeout", 64'd0, 64'd1);
        end else begin
            d = desc_q.pop_front();
            for (int b = 0; b <= d.len; b++) begin
                if (rand_ready && ($urandom_range(0, 3) == 0)) begin
                    @(posedge clk);
                    #1;
                end
                send_beat($urandom, d, b);
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((ostd_cnt_o != 0 || m_wvalid_o || exp_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_ostd"}, ostd_cnt_o, 3'd0);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_sb_empty"}, exp_q.size(), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] t1_strb [4];
    desc_m_t    d;

    initial begin
        t1_strb = '{4'b1100, 4'b1111, 4'b1111, 4'b0011};

        @(negedge clk);
        check("rst_wvalid", m_wvalid_o, 1'b0);
        check("rst_wlast", m_wlast_o, 1'b0);
        check("rst_wstrb", m_wstrb_o, 4'd0);
        check("rst_wdata", m_wdata_o, 32'd0);
        check("rst_ostd", ostd_cnt_o, 3'd0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_atx_rdy", atx_rdy, 1'b1);
        check("rst_wdata_rdy", atx_wdata_rdy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unaligned 4-beat burst, one beat at a time so the 1-cycle latency is visible.
        push_desc(3, 2, 1);
        d = desc_q.pop_front();
        for (int b = 0; b < 4; b++) begin
            send_beat(32'h1000_0000 + 32'(b), d, b);
            @(negedge clk);
            check("t1_valid", m_wvalid_o, 1'b1);
            check("t1_strb", m_wstrb_o, t1_strb[b]);
            check("t1_last", m_wlast_o, b == 3);
            @(posedge clk);
            #1;
        end
        drain("t1");

        // Single beat with interior bytes.
        push_desc(0, 1, 2);
        d = desc_q.pop_front();
        send_beat(32'hAABBCCDD, d, 0);
        @(negedge clk);
        check("t2_strb", m_wstrb_o, 4'b0110);
        check("t2_last", m_wlast_o, 1'b1);
`ifdef ADMA_DM_W_ZERO_PAD_EN
        check("t2_data", m_wdata_o, 32'h00BBCC00);
`else
        check("t2_data", m_wdata_o, 32'hAABBCCDD);
`endif
        @(posedge clk);
        #1;
        drain("t2");

        // Fill the descriptor queue, then a fifth push waits for the first burst's last beat.
        for (int i = 0; i < 4; i++) push_desc(1, $urandom_range(0, 3), $urandom_range(0, 3));
        @(negedge clk);
        check("t3_full_rdy", atx_rdy, 1'b0);
        check("t3_full_ostd", ostd_cnt_o, 3'd4);
        @(posedge clk);
        #1;
        fork
            push_desc(1, 3, 0);
            begin
                desc_m_t d1;
                d1 = desc_q.pop_front();
                send_beat($urandom, d1, 0);
                @(negedge clk);
                check("t3_blocked", atx_rdy, 1'b0);
                @(posedge clk);
                #1;
                send_beat($urandom, d1, 1);
                @(negedge clk);
                check("t3_unblocked", atx_rdy, 1'b1);
            end
        join
        for (int i = 0; i < 4; i++) send_burst();
        drain("t3");

        // Back-to-back bursts with no bubble on W.
        push_desc(1, 0, 3);
        push_desc(0, 0, 3);
        w_cyc_q.delete();
        w_last_q.delete();
        for (int i = 0; i < 2; i++) send_burst();
        drain("t4");
        check("t4_beats", w_cyc_q.size(), 64'd3);
        if (w_cyc_q.size() == 3) begin
            check("t4_gap1", w_cyc_q[1] - w_cyc_q[0], 64'd1);
            check("t4_gap2", w_cyc_q[2] - w_cyc_q[1], 64'd1);
            check("t4_last", {w_last_q[0], w_last_q[1], w_last_q[2]}, 3'b011);
        end

        // Random descriptors, data gaps and 50% WREADY stalls.
        rand_ready = 1'b1;
        fork
            for (int i = 0; i < 20; i++)
                push_desc($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3));
            for (int i = 0; i < 20; i++) send_burst();
        join
        drain("t5");
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset after beat 2 of a 4-beat burst, then a fresh burst from beat 0.
        push_desc(3, 0, 3);
        d = desc_q.pop_front();
        send_beat(32'h1111_1111, d, 0);
        send_beat(32'h2222_2222, d, 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        desc_q.delete();
        check("t6_wvalid", m_wvalid_o, 1'b0);
        check("t6_wlast", m_wlast_o, 1'b0);
        check("t6_wstrb", m_wstrb_o, 4'd0);
        check("t6_wdata", m_wdata_o, 32'd0);
        check("t6_ostd", ostd_cnt_o, 3'd0);
        check("t6_busy", busy_o, 1'b0);
        check("t6_atx_rdy", atx_rdy, 1'b1);
        check("t6_wdata_rdy", atx_wdata_rdy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_desc(1, 1, 3);
        d = desc_q.pop_front();
        send_beat(32'h3333_3333, d, 0);
        @(negedge clk);
        check("t6_new_strb0", m_wstrb_o, 4'b1110);
        check("t6_new_last0", m_wlast_o, 1'b0);
        @(posedge clk);
        #1;
        send_beat(32'h4444_4444, d, 1);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
